// File: rtl/dram_video_arb.sv
// dram_video_arb: slotted DRAM arbiter sharing one DRAM between a video fetcher and a CPU.
// The next owner is decided at pre_cend and loaded at cend; read data is captured at pre_cend.
module dram_video_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pre_cend,
    input  logic        cend,
    input  logic        video_go,
    input  logic [1:0]  video_bw,
    input  logic [20:0] video_addr,
    output logic        video_next,
    output logic        video_strobe,
    output logic [15:0] video_data,
    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic [20:0] cpu_addr,
    input  logic [15:0] cpu_wrdata,
    output logic        cpu_next,
    output logic        cpu_strobe,
    output logic [15:0] cpu_rddata,
    output logic        dram_go,
    output logic        dram_rnw,
    output logic [20:0] dram_addr,
    output logic [15:0] dram_wrdata,
    input  logic [15:0] dram_rddata,
    output logic [1:0]  owner
);
    typedef enum logic [1:0] {
        OWN_IDLE  = 2'b00,
        OWN_VIDEO = 2'b01,
        OWN_CPU   = 2'b10
    } own_e;

    own_e        state;
    own_e        state_nxt;
    own_e        grant;
    own_e        pend;
    logic [2:0]  slot;
    logic [2:0]  nslot;
    logic        hit;
    logic        vid_win;
    logic        pre_seen;
    logic        v_pend;
    logic        c_pend;
    logic        pend_rnw;
    logic [20:0] pend_addr;
    logic [15:0] pend_wrdata;

    assign owner = state;

    always_comb begin
        nslot = slot + 3'd1;
        hit   = 1'b0;
        unique case (video_bw)
            2'b00:   hit = (nslot == 3'd7);
            2'b01:   hit = (nslot[1:0] == 2'd3);
            2'b10:   hit = nslot[0];
            default: hit = 1'b1;
        endcase
        vid_win = video_go && hit;
        grant   = OWN_IDLE;
        unique case (1'b1)
            vid_win:             grant = OWN_VIDEO;
            !vid_win && cpu_req: grant = OWN_CPU;
            default:             grant = OWN_IDLE;
        endcase
    end

    // a cend not preceded by its pre_cend carries no valid grant
    always_comb begin
        state_nxt = state;
        if (cend) begin
            state_nxt = pre_seen ? pend : OWN_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OWN_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot         <= 3'd0;
            pre_seen     <= 1'b0;
            pend         <= OWN_IDLE;
            pend_rnw     <= 1'b1;
            pend_addr    <= 21'd0;
            pend_wrdata  <= 16'd0;
            v_pend       <= 1'b0;
            c_pend       <= 1'b0;
            video_next   <= 1'b0;
            video_strobe <= 1'b0;
            video_data   <= 16'd0;
            cpu_next     <= 1'b0;
            cpu_strobe   <= 1'b0;
            cpu_rddata   <= 16'd0;
            dram_go      <= 1'b0;
            dram_rnw     <= 1'b1;
            dram_addr    <= 21'd0;
            dram_wrdata  <= 16'd0;
        end else begin
            video_next   <= 1'b0;
            video_strobe <= 1'b0;
            cpu_next     <= 1'b0;
            cpu_strobe   <= 1'b0;
            if (pre_cend) begin
                pre_seen    <= 1'b1;
                pend        <= grant;
                pend_addr   <= (grant == OWN_VIDEO) ? video_addr : cpu_addr;
                pend_wrdata <= cpu_wrdata;
                pend_rnw    <= (grant == OWN_CPU) ? cpu_rnw : 1'b1;
                if (state == OWN_VIDEO) begin
                    video_data <= dram_rddata;
                    v_pend     <= 1'b1;
                end
                if (state == OWN_CPU && dram_rnw) begin
                    cpu_rddata <= dram_rddata;
                    c_pend     <= 1'b1;
                end
            end
            if (cend) begin
                slot         <= slot + 3'd1;
                pre_seen     <= 1'b0;
                v_pend       <= 1'b0;
                c_pend       <= 1'b0;
                video_strobe <= v_pend;
                cpu_strobe   <= c_pend;
                video_next   <= (state_nxt == OWN_VIDEO);
                cpu_next     <= (state_nxt == OWN_CPU);
                dram_go      <= (state_nxt != OWN_IDLE);
                dram_rnw     <= (state_nxt == OWN_IDLE) ? 1'b1 : pend_rnw;
                if (state_nxt != OWN_IDLE) begin
                    dram_addr <= pend_addr;
                end
                if (state_nxt == OWN_CPU) begin
                    dram_wrdata <= pend_wrdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_dram_video_arb.sv
// Bench for dram_video_arb: stimulus pushes expected pulses into queues,
// a monitor pops and compares whenever a next/strobe pulse appears.
module tb_dram_video_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pre_cend = 1'b0;
    logic        cend = 1'b0;
    logic        video_go = 1'b0;
    logic [1:0]  video_bw = 2'b01;
    logic [20:0] video_addr = 21'd0;
    logic        video_next;
    logic        video_strobe;
    logic [15:0] video_data;
    logic        cpu_req = 1'b0;
    logic        cpu_rnw = 1'b1;
    logic [20:0] cpu_addr = 21'd0;
    logic [15:0] cpu_wrdata = 16'd0;
    logic        cpu_next;
    logic        cpu_strobe;
    logic [15:0] cpu_rddata;
    logic        dram_go;
    logic        dram_rnw;
    logic [20:0] dram_addr;
    logic [15:0] dram_wrdata;
    logic [15:0] dram_rddata = 16'hDEAD;
    logic [1:0]  owner;

    always #5 clk = ~clk;

    dram_video_arb dut (
        .clk(clk), .rst_n(rst_n), .pre_cend(pre_cend), .cend(cend),
        .video_go(video_go), .video_bw(video_bw), .video_addr(video_addr),
        .video_next(video_next), .video_strobe(video_strobe),
        .video_data(video_data), .cpu_req(cpu_req), .cpu_rnw(cpu_rnw),
        .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata), .cpu_next(cpu_next),
        .cpu_strobe(cpu_strobe), .cpu_rddata(cpu_rddata), .dram_go(dram_go),
        .dram_rnw(dram_rnw), .dram_addr(dram_addr), .dram_wrdata(dram_wrdata),
        .dram_rddata(dram_rddata), .owner(owner)
    );

    typedef struct {
        logic [20:0] a;
        logic [15:0] d;
        logic        rnw;
    } cpu_ev_t;

    logic [20:0] vnext_q[$];
    cpu_ev_t     cnext_q[$];
    logic [15:0] vstb_q[$];
    logic [15:0] cstb_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int vnext_cnt = 0;
    int cnext_cnt = 0;
    int vstb_cnt = 0;
    int cstb_cnt = 0;
    int coincide_cnt = 0;

    logic [2:0] m_slot = 3'd0;
    logic [1:0] m_own = 2'd0;
    logic       m_rnw = 1'b1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [20:0] mon_a;
    cpu_ev_t     mon_c;
    logic [15:0] mon_d;

    always @(posedge clk) begin
        #1;
        if (video_next && video_strobe) coincide_cnt++;
        if (video_next) begin
            vnext_cnt++;
            check("video_next expected", vnext_q.size() != 0, 1);
            if (vnext_q.size() != 0) begin
                mon_a = vnext_q.pop_front();
                check("vnext owner", owner, 2'b01);
                check("vnext dram_go", dram_go, 1'b1);
                check("vnext dram_rnw", dram_rnw, 1'b1);
                check("vnext dram_addr", dram_addr, mon_a);
            end
        end
        if (cpu_next) begin
            cnext_cnt++;
            check("cpu_next expected", cnext_q.size() != 0, 1);
            if (cnext_q.size() != 0) begin
                mon_c = cnext_q.pop_front();
                check("cnext owner", owner, 2'b10);
                check("cnext dram_go", dram_go, 1'b1);
                check("cnext dram_rnw", dram_rnw, mon_c.rnw);
                check("cnext dram_addr", dram_addr, mon_c.a);
                if (!mon_c.rnw) check("cnext dram_wrdata", dram_wrdata, mon_c.d);
            end
        end
        if (video_strobe) begin
            vstb_cnt++;
            check("video_strobe expected", vstb_q.size() != 0, 1);
            if (vstb_q.size() != 0) begin
                mon_d = vstb_q.pop_front();
                check("video_data", video_data, mon_d);
            end
        end
        if (cpu_strobe) begin
            cstb_cnt++;
            check("cpu_strobe expected", cstb_q.size() != 0, 1);
            if (cstb_q.size() != 0) begin
                mon_d = cstb_q.pop_front();
                check("cpu_rddata", cpu_rddata, mon_d);
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, " owner"}, owner, 2'b00);
        check({tag, " dram_go"}, dram_go, 1'b0);
        check({tag, " dram_rnw"}, dram_rnw, 1'b1);
        check({tag, " pulses"}, {video_next, video_strobe, cpu_next, cpu_strobe}, 4'b0);
        check({tag, " dram_addr"}, dram_addr, 21'd0);
        check({tag, " dram_wrdata"}, dram_wrdata, 16'd0);
        check({tag, " video_data"}, video_data, 16'd0);
        check({tag, " cpu_rddata"}, cpu_rddata, 16'd0);
    endtask

    // one DRAM cycle: two filler clocks, optional pre_cend, then cend
    task automatic run_cycle(input bit do_pre, input bit rst_mid,
                             input logic [15:0] rd);
        logic [2:0]  n;
        bit          h;
        logic [1:0]  g;
        logic        nrnw;
        cpu_ev_t     ev;
        logic [20:0] sv_va;
        logic [20:0] sv_ca;
        logic [15:0] sv_cd;
        logic        sv_go;
        logic        sv_req;
        logic        sv_rnw;
        g = 2'd0;
        nrnw = 1'b1;
        repeat (2) @(negedge clk);
        if (do_pre) begin
            n = m_slot + 3'd1;
            case (video_bw)
                2'b00:   h = (n == 3'd7);
                2'b01:   h = (n[1:0] == 2'd3);
                2'b10:   h = n[0];
                default: h = 1'b1;
            endcase
            if (video_go && h) g = 2'd1;
            else if (cpu_req) g = 2'd2;
            if (g == 2'd2) nrnw = cpu_rnw;
            if (!rst_mid) begin
                if (m_own == 2'd1) vstb_q.push_back(rd);
                if (m_own == 2'd2 && m_rnw) cstb_q.push_back(rd);
                if (g == 2'd1) vnext_q.push_back(video_addr);
                if (g == 2'd2) begin
                    ev.a = cpu_addr;
                    ev.d = cpu_wrdata;
                    ev.rnw = cpu_rnw;
                    cnext_q.push_back(ev);
                end
            end
            pre_cend = 1'b1;
            dram_rddata = rd;
            @(negedge clk);
            pre_cend = 1'b0;
            dram_rddata = 16'hDEAD;
        end
        if (rst_mid) begin
            rst_n = 1'b0;
            #2;
            check_reset("midreset");
            m_slot = 3'd0;
            m_own = 2'd0;
            g = 2'd0;
            nrnw = 1'b1;
            #1;
            rst_n = 1'b1;
        end
        sv_va = video_addr;
        sv_ca = cpu_addr;
        sv_cd = cpu_wrdata;
        sv_go = video_go;
        sv_req = cpu_req;
        sv_rnw = cpu_rnw;
        video_addr = ~sv_va;
        cpu_addr = ~sv_ca;
        cpu_wrdata = ~sv_cd;
        video_go = ~sv_go;
        cpu_req = ~sv_req;
        cpu_rnw = ~sv_rnw;
        cend = 1'b1;
        @(negedge clk);
        cend = 1'b0;
        video_addr = sv_va;
        cpu_addr = sv_ca;
        cpu_wrdata = sv_cd;
        video_go = sv_go;
        cpu_req = sv_req;
        cpu_rnw = sv_rnw;
        m_slot = m_slot + 3'd1;
        m_own = (do_pre && !rst_mid) ? g : 2'd0;
        m_rnw = (do_pre && !rst_mid) ? nrnw : 1'b1;
        check("cycle owner", owner, m_own);
        check("cycle dram_go", dram_go, m_own != 2'd0);
    endtask

    int base;
    int base2;

    initial begin
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        video_bw = 2'b01;
        video_go = 1'b1;
        cpu_req = 1'b0;
        video_addr = 21'h00100;
        base = vnext_cnt;
        for (int k = 0; k < 16; k++) begin
            run_cycle(1'b1, 1'b0, 16'h0100 + 16'(k));
            check("bw01 owner", owner, (k % 4 == 2) ? 2'b01 : 2'b00);
            video_addr = video_addr + 21'd1;
        end
        check("bw01 video_next count", vnext_cnt - base, 4);

        video_bw = 2'b11;
        cpu_req = 1'b1;
        cpu_rnw = 1'b1;
        cpu_addr = 21'h00555;
        base = cnext_cnt;
        base2 = coincide_cnt;
        for (int k = 0; k < 8; k++) begin
            run_cycle(1'b1, 1'b0, 16'hA5C3);
            check("bw11 owner", owner, 2'b01);
            video_addr = video_addr + 21'd1;
        end
        check("bw11 cpu_next count", cnext_cnt - base, 0);
        check("bw11 video_data", video_data, 16'hA5C3);
        check("bw11 back-to-back", coincide_cnt - base2, 7);

        video_go = 1'b0;
        cpu_req = 1'b0;
        base = vstb_cnt;
        run_cycle(1'b1, 1'b0, 16'h1111);
        check("drop go owner", owner, 2'b00);
        check("drop go strobe", vstb_cnt - base, 1);
        cpu_req = 1'b1;
        cpu_addr = 21'h00777;
        run_cycle(1'b1, 1'b0, 16'h2222);
        check("hit slot to cpu", owner, 2'b10);

        video_bw = 2'b00;
        base = cstb_cnt;
        for (int k = 0; k < 9; k++) begin
            cpu_addr = 21'h02000 + 21'(k);
            run_cycle(1'b1, 1'b0, 16'h3000 + 16'(k));
            check("bw00 cpu owner", owner, 2'b10);
        end
        check("bw00 cpu_strobe count", cstb_cnt - base, 9);

        cpu_rnw = 1'b0;
        cpu_addr = 21'h1ABCD;
        cpu_wrdata = 16'h1234;
        run_cycle(1'b1, 1'b0, 16'h4444);
        check("write dram_rnw", dram_rnw, 1'b0);
        check("write dram_addr", dram_addr, 21'h1ABCD);
        check("write dram_wrdata", dram_wrdata, 16'h1234);
        cpu_req = 1'b0;
        cpu_rnw = 1'b1;
        base = cstb_cnt;
        run_cycle(1'b1, 1'b0, 16'h5555);
        check("write no strobe", cstb_cnt - base, 0);
        check("idle hold addr", dram_addr, 21'h1ABCD);
        check("idle hold wrdata", dram_wrdata, 16'h1234);

        video_bw = 2'b11;
        video_go = 1'b1;
        video_addr = 21'h0AAAA;
        run_cycle(1'b1, 1'b0, 16'h6666);
        base = vstb_cnt;
        run_cycle(1'b0, 1'b0, 16'h7777);
        check("no pre_cend owner", owner, 2'b00);
        check("no pre_cend strobe", vstb_cnt - base, 0);

        run_cycle(1'b1, 1'b0, 16'h8888);
        base = vstb_cnt;
        run_cycle(1'b1, 1'b1, 16'h9999);
        check("midreset no strobe", vstb_cnt - base, 0);

        video_bw = 2'b01;
        for (int k = 0; k < 4; k++) begin
            run_cycle(1'b1, 1'b0, 16'hB000 + 16'(k));
            check("post reset owner", owner, (k == 1) ? 2'b01 : 2'b00);
        end

        video_go = 1'b0;
        cpu_req = 1'b0;
        run_cycle(1'b1, 1'b0, 16'hC000);
        run_cycle(1'b1, 1'b0, 16'hC001);
        check("vnext queue empty", vnext_q.size(), 0);
        check("cnext queue empty", cnext_q.size(), 0);
        check("vstb queue empty", vstb_q.size(), 0);
        check("cstb queue empty", cstb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
